// File: rtl/quad_step_decoder_if.sv
// Encoder-side bundle for quad_step_decoder: raw A/B phases and controls in, step/dir/err events out.
// The pos bus and its POS_W width exist only when QDEC_POS_EN is defined.
interface quad_step_decoder_if
`ifdef QDEC_POS_EN
  #(parameter int POS_W = 16)
`endif
  ;
  logic a_in;
  logic b_in;
  logic enable;
  logic err_clr;
  logic step;
  logic dir;
  logic err;
`ifdef QDEC_POS_EN
  logic [POS_W-1:0] pos;

  modport master (output a_in, b_in, enable, err_clr, input step, dir, err, pos);
  modport slave  (input a_in, b_in, enable, err_clr, output step, dir, err, pos);
`else
  modport master (output a_in, b_in, enable, err_clr, input step, dir, err);
  modport slave  (input a_in, b_in, enable, err_clr, output step, dir, err);
`endif
endinterface

// File: rtl/quad_step_decoder.sv
// Quadrature A/B front end: synchronise, glitch-filter, decode Gray steps into step/dir and flag illegal jumps.
// Optional up/down position register enabled by defining QDEC_POS_EN.
module quad_step_decoder #(
  parameter int FILT_CYC = 2,
  parameter int FILT_W   = 4
`ifdef QDEC_POS_EN
  , parameter int POS_W  = 16
`endif
) (
  input  logic               clk,
  input  logic               reset,
  quad_step_decoder_if.slave bus
);

  typedef enum logic {INIT, TRACK} state_t;

  localparam logic [FILT_W-1:0] FILT_LAST = FILT_W'(FILT_CYC);
  localparam logic [FILT_W:0]   INIT_CYC  = (FILT_W+1)'(FILT_CYC) + (FILT_W+1)'(1);

  logic              a_s1, a_s2, b_s1, b_s2;
  logic [1:0]        sync_vld;
  logic              primed;
  logic [1:0]        samp;
  logic [1:0]        filt, cand;
  logic [FILT_W-1:0] cnt, cnt_inc;
  logic              filt_upd;

  state_t            state_q, state_d;
  logic [1:0]        prev_q, prev_d;
  logic [FILT_W:0]   init_cnt_q, init_cnt_d, init_cnt_inc;
  logic              step_q, step_d;
  logic              dir_q, dir_d;
  logic              err_q, err_d;
  logic              is_up, is_down, is_jump;
`ifdef QDEC_POS_EN
  logic [POS_W-1:0]  pos_q, pos_d;
`endif

  // Two-stage synchronisers; sync_vld marks when the pipeline holds real pin samples again after reset.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      a_s1     <= 1'b0;
      a_s2     <= 1'b0;
      b_s1     <= 1'b0;
      b_s2     <= 1'b0;
      sync_vld <= 2'b00;
    end else begin
      a_s1     <= bus.a_in;
      a_s2     <= a_s1;
      b_s1     <= bus.b_in;
      b_s2     <= b_s1;
      sync_vld <= {sync_vld[0], 1'b1};
    end
  end

  assign primed  = sync_vld[1];
  assign samp    = {a_s2, b_s2};
  assign cnt_inc = (samp == cand) ? cnt + FILT_W'(1) : '0;

  // Joint filter: a new value must be seen on FILT_CYC+1 consecutive samples before it becomes filt.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      filt     <= 2'b00;
      cand     <= 2'b00;
      cnt      <= '0;
      filt_upd <= 1'b0;
    end else begin
      filt_upd <= 1'b0;
      if (samp == filt) begin
        cand <= filt;
        cnt  <= '0;
      end else begin
        cand <= samp;
        if (cnt_inc == FILT_LAST) begin
          filt     <= samp;
          cnt      <= '0;
          filt_upd <= 1'b1;
        end else begin
          cnt <= cnt_inc;
        end
      end
    end
  end

  assign is_up        = (filt == {~prev_q[0], prev_q[1]});
  assign is_down      = (filt == {prev_q[0], ~prev_q[1]});
  assign is_jump      = ((filt ^ prev_q) == 2'b11);
  assign init_cnt_inc = init_cnt_q + (FILT_W+1)'(1);

  always_comb begin
    state_d    = state_q;
    prev_d     = prev_q;
    init_cnt_d = init_cnt_q;
    step_d     = 1'b0;
    dir_d      = dir_q;
    err_d      = err_q;
`ifdef QDEC_POS_EN
    pos_d      = pos_q;
`endif
    if (bus.err_clr) begin
      err_d = 1'b0;
    end
    case (state_q)
      INIT: begin
        if (filt_upd) begin
          prev_d     = filt;
          init_cnt_d = '0;
          state_d    = TRACK;
        end else if (primed && samp == 2'b00 && filt == 2'b00) begin
          init_cnt_d = init_cnt_inc;
          if (init_cnt_inc == INIT_CYC) begin
            prev_d     = 2'b00;
            init_cnt_d = '0;
            state_d    = TRACK;
          end
        end else begin
          init_cnt_d = '0;
        end
      end
      TRACK: begin
        // prev always follows filt, even while disabled, so re-enabling decodes from the true position.
        if (filt_upd) begin
          prev_d = filt;
          if (bus.enable) begin
            if (is_up) begin
              step_d = 1'b1;
              dir_d  = 1'b1;
`ifdef QDEC_POS_EN
              pos_d  = pos_q + POS_W'(1);
`endif
            end else if (is_down) begin
              step_d = 1'b1;
              dir_d  = 1'b0;
`ifdef QDEC_POS_EN
              pos_d  = pos_q - POS_W'(1);
`endif
            end else if (is_jump) begin
              err_d = 1'b1;
            end
          end
        end
      end
      default: state_d = INIT;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= INIT;
      prev_q     <= 2'b00;
      init_cnt_q <= '0;
      step_q     <= 1'b0;
      dir_q      <= 1'b0;
      err_q      <= 1'b0;
`ifdef QDEC_POS_EN
      pos_q      <= '0;
`endif
    end else begin
      state_q    <= state_d;
      prev_q     <= prev_d;
      init_cnt_q <= init_cnt_d;
      step_q     <= step_d;
      dir_q      <= dir_d;
      err_q      <= err_d;
`ifdef QDEC_POS_EN
      pos_q      <= pos_d;
`endif
    end
  end

  assign bus.step = step_q;
  assign bus.dir  = dir_q;
  assign bus.err  = err_q;
`ifdef QDEC_POS_EN
  assign bus.pos  = pos_q;
`endif

endmodule

// File: tb/tb_quad_step_decoder.sv
// Bench for quad_step_decoder: dut0 with FILT_CYC=0 and dut2 with FILT_CYC=2, checked by vector tables and step scoreboards.
// Position checks are active when QDEC_POS_EN is defined.
module tb_quad_step_decoder;

  typedef struct {
    logic a;
    logic b;
    logic en;
    logic step;
    logic dir;
    logic err;
  } vec_t;

  typedef struct {
    int          cyc;
    logic        dir;
    logic [15:0] pos;
  } exp_t;

  logic clk = 1'b0;
  logic reset;
  int   cyc = 0;
  int   n_checks = 0;
  int   n_fail = 0;
  exp_t q0[$];
  exp_t q2[$];
  exp_t e0, e2;
  logic [15:0] pos0 = 16'd0;
  logic [15:0] pos2 = 16'd0;
  vec_t tbl1[11];
  vec_t tbl2[5];

`ifdef QDEC_POS_EN
  quad_step_decoder_if #(.POS_W(16)) bus0();
  quad_step_decoder_if #(.POS_W(16)) bus2();
  quad_step_decoder #(.FILT_CYC(0), .FILT_W(4), .POS_W(16)) dut0 (.clk(clk), .reset(reset), .bus(bus0));
  quad_step_decoder #(.FILT_CYC(2), .FILT_W(4), .POS_W(16)) dut2 (.clk(clk), .reset(reset), .bus(bus2));
`else
  quad_step_decoder_if bus0();
  quad_step_decoder_if bus2();
  quad_step_decoder #(.FILT_CYC(0), .FILT_W(4)) dut0 (.clk(clk), .reset(reset), .bus(bus0));
  quad_step_decoder #(.FILT_CYC(2), .FILT_W(4)) dut2 (.clk(clk), .reset(reset), .bus(bus2));
`endif

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    n_checks++;
    if (actual !== expected) begin
      n_fail++;
      $display("[TB] FAIL %s: got %0h, expected %0h (cycle %0d)", name, actual, expected, cyc);
    end
  endtask

  // Drives one table record onto dut0, queues the step it should cause, then checks the settled levels.
  task automatic applyStimulus(input vec_t v);
    bus0.a_in   = v.a;
    bus0.b_in   = v.b;
    bus0.enable = v.en;
    if (v.step) begin
      pos0 = v.dir ? pos0 + 16'd1 : pos0 - 16'd1;
      q0.push_back('{cyc + 4, v.dir, pos0});
    end
    tick(10);
    checkOutput("vec_err", bus0.err, v.err);
    checkOutput("vec_dir", bus0.dir, v.dir);
  endtask

  always @(negedge clk) begin
    if (!reset && bus0.step) begin
      if (q0.size() == 0) begin
        checkOutput("step0_expected_pending", q0.size(), 1);
      end else begin
        e0 = q0.pop_front();
        checkOutput("step0_cycle", cyc, e0.cyc);
        checkOutput("step0_dir", bus0.dir, e0.dir);
`ifdef QDEC_POS_EN
        checkOutput("step0_pos", bus0.pos, e0.pos);
`endif
      end
    end
  end

  always @(negedge clk) begin
    if (!reset && bus2.step) begin
      if (q2.size() == 0) begin
        checkOutput("step2_expected_pending", q2.size(), 1);
      end else begin
        e2 = q2.pop_front();
        checkOutput("step2_cycle", cyc, e2.cyc);
        checkOutput("step2_dir", bus2.dir, e2.dir);
`ifdef QDEC_POS_EN
        checkOutput("step2_pos", bus2.pos, e2.pos);
`endif
      end
    end
  end

  initial begin
    // {a, b, en, step expected, dir after, err after}
    tbl1 = '{
      '{1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0},
      '{1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0},
      '{1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0},
      '{1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0},
      '{1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0},
      '{1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0},
      '{1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0},
      '{1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0},
      '{1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0},
      '{1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0},
      '{1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1}
    };
    tbl2 = '{
      '{1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0},
      '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0},
      '{1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0},
      '{1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0},
      '{1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0}
    };

    reset        = 1'b1;
    bus0.a_in    = 1'b0;
    bus0.b_in    = 1'b0;
    bus0.enable  = 1'b1;
    bus0.err_clr = 1'b0;
    bus2.a_in    = 1'b0;
    bus2.b_in    = 1'b0;
    bus2.enable  = 1'b1;
    bus2.err_clr = 1'b0;
    tick(3);
    checkOutput("rst_step0", bus0.step, 1'b0);
    checkOutput("rst_dir0", bus0.dir, 1'b0);
    checkOutput("rst_err0", bus0.err, 1'b0);
    checkOutput("rst_step2", bus2.step, 1'b0);
    checkOutput("rst_err2", bus2.err, 1'b0);
`ifdef QDEC_POS_EN
    checkOutput("rst_pos0", bus0.pos, 16'd0);
`endif
    reset = 1'b0;
    tick(10);

    for (int i = 0; i < 11; i++) applyStimulus(tbl1[i]);

    // Second jump 11->00 with err_clr landing on the same edge as the illegal decode.
    bus0.a_in = 1'b0;
    bus0.b_in = 1'b0;
    tick(3);
    bus0.err_clr = 1'b1;
    tick(1);
    bus0.err_clr = 1'b0;
    tick(6);
    checkOutput("jump_clr_err", bus0.err, 1'b1);
    checkOutput("jump_clr_dir", bus0.dir, 1'b1);
    bus0.err_clr = 1'b1;
    tick(1);
    bus0.err_clr = 1'b0;
    checkOutput("clr_alone_err", bus0.err, 1'b0);
    tick(5);

    for (int i = 0; i < 5; i++) applyStimulus(tbl2[i]);

    // Reset while a down step pulse is high, with inputs parked at 11.
    bus0.a_in = 1'b1;
    bus0.b_in = 1'b1;
    pos0 = pos0 - 16'd1;
    q0.push_back('{cyc + 4, 1'b0, pos0});
    tick(4);
    @(negedge clk);
    #2 reset = 1'b1;
    #1;
    checkOutput("midrst_step", bus0.step, 1'b0);
    checkOutput("midrst_err", bus0.err, 1'b0);
    checkOutput("midrst_dir", bus0.dir, 1'b0);
`ifdef QDEC_POS_EN
    checkOutput("midrst_pos", bus0.pos, 16'd0);
`endif
    pos0 = 16'd0;
    pos2 = 16'd0;
    tick(2);
    reset = 1'b0;
    tick(12);
    checkOutput("init_absorb_err", bus0.err, 1'b0);
    checkOutput("init_absorb_dir", bus0.dir, 1'b0);
    bus0.a_in = 1'b0;
    pos0 = pos0 + 16'd1;
    q0.push_back('{cyc + 4, 1'b1, pos0});
    tick(10);
    checkOutput("post_rst_err", bus0.err, 1'b0);
    checkOutput("post_rst_dir", bus0.dir, 1'b1);

    // FILT_CYC=2: a 2-cycle glitch on A is swallowed, a 3-cycle pulse gives an up then a down step.
    bus2.a_in = 1'b1;
    tick(2);
    bus2.a_in = 1'b0;
    tick(12);
    checkOutput("glitch_dir2", bus2.dir, 1'b0);
    checkOutput("glitch_err2", bus2.err, 1'b0);
    bus2.a_in = 1'b1;
    pos2 = pos2 + 16'd1;
    q2.push_back('{cyc + 6, 1'b1, pos2});
    tick(3);
    bus2.a_in = 1'b0;
    pos2 = pos2 - 16'd1;
    q2.push_back('{cyc + 6, 1'b0, pos2});
    tick(12);
    checkOutput("pulse3_err2", bus2.err, 1'b0);
    checkOutput("pulse3_dir2", bus2.dir, 1'b0);

    checkOutput("pending0", q0.size(), 0);
    checkOutput("pending2", q2.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/quad_step_decoder.md
Name: quad_step_decoder

Overview:
- Quadrature (A/B) incremental-encoder front end.
- Turns two raw, asynchronous phase inputs into a one-cycle `step` pulse and a `dir` level. These match the enable/up-down control pair the team's up/down counters consume.
- Synchronises and glitch-filters the inputs, decodes Gray-code transitions and flags illegal jumps.
- Sits between the board-level encoder pins and any position/step counter.

Parameters:
- FILT_CYC, 2, extra consecutive stable cycles required before a new A/B value is accepted (0 = accept after 1 sample).
- FILT_W, 4, width of filter counter; FILT_CYC must be < 2**FILT_W.
- POS_W, 16, width of optional position register.

Ports:
- clk  input  1  system clock, all state on rising edge.
- reset  input  1  asynchronous, active-high reset; one clock; reset is asynchronous and active-high.
- a_in  input  1  raw encoder phase A, asynchronous to clk.
- b_in  input  1  raw encoder phase B, asynchronous to clk.
- enable  input  1  1 = emit step/err events; 0 = track silently.
- err_clr  input  1  synchronous clear of err.
- step  output  1  one-cycle pulse per legal quadrature edge.
- dir  output  1  1 = up, 0 = down; valid with step, holds last value otherwise.
- err  output  1  sticky illegal-transition flag.
- pos  output  POS_W  signed-agnostic position (only with QDEC_POS_EN).

Behaviour:
- Reset (async, asserted): sync FFs, filtered state, candidate, filter count = 0.
  - step=0, dir=0, err=0, pos=0; FSM -> INIT.
  - Deassertion is not required to be synchronous externally; all FFs clear immediately.
- Sync: 2-FF synchroniser per input; the synchronised pair is S={A,B}.
- Filter (joint on the 2-bit vector), filtered value F:
  - If S == F: counter = 0.
  - Else if S != candidate: candidate = S, counter = 0.
  - Else counter++. When counter == FILT_CYC (checked on the sample that matches), F <= candidate and counter = 0.
  - With FILT_CYC=0, F updates the edge after S first differs.
  - Any S change before acceptance restarts filtering; a pulse shorter than FILT_CYC+1 cycles never reaches F.
- FSM states:
  - INIT: the first F update after reset is not evaluated. prev <= F; go to TRACK. Also leaves INIT after FILT_CYC+1 cycles of stable S == 00 with no update (prev = 00).
  - TRACK: on each F update compare prev -> F, then prev <= F.
- Decode, F={A,B}:
  - Up sequence 00->10->11->01->00 (A leads B). Down sequence is the reverse.
  - Legal up step, enable=1: step=1 next cycle, dir=1.
  - Legal down step, enable=1: step=1, dir=0.
  - Both bits changed: err <= 1, no step, dir unchanged.
  - enable=0: prev still updated, step stays 0, err not set.
- Latency: with FILT_CYC=0, step is high for exactly 1 cycle, 4 rising edges after a_in/b_in changes (setup met). Each extra FILT_CYC adds 1 cycle.
- Back-to-back legal edges produce back-to-back step pulses. Max rate is one step per FILT_CYC+1 cycles.
- err_clr=1 clears err next edge. A simultaneous illegal event wins: err stays 1.
- Reset mid-pulse: step drops immediately; the post-reset first state is absorbed by INIT, giving no spurious err or step.

Optional Feature:
- Macro QDEC_POS_EN.
- Defined: pos port and POS_W register present. pos increments on each up step and decrements on each down step, in the same cycle step asserts. It wraps modulo 2**POS_W (all-ones +1 -> 0, 0 -1 -> all-ones). It is unaffected by err events and err_clr.
- Undefined: no pos port or register; the remaining behaviour is identical.

Test Plan:
- Reset, then drive A/B 00->10->11->01->00 with 10-cycle spacing, enable=1, FILT_CYC=0 -> 4 step pulses, each exactly 1 cycle and 4 edges after the input change; dir=1; err=0; pos=4.
- Reverse sequence from 00 (00->01->11->10->00) -> 4 pulses with dir=0; pos returns 4->0; one more down step gives pos=0xFFFF.
- FILT_CYC=2, A glitch 2 cycles wide -> no step, F unchanged. The same edge held 3 cycles -> 1 step at 6 edges latency.
- Jump 00->11 in one sample -> err=1, no step, dir unchanged. Assert err_clr together with a second 11->00 jump -> err stays 1. err_clr alone -> err=0.
- enable=0 during 3 legal up edges, then enable=1 and 1 more up edge -> exactly 1 step, dir=1, err=0 (prev tracked while disabled).
- Hold A/B=11, assert reset mid-step pulse, release -> step/err/pos=0 at once; INIT absorbs 00->11 with no err; next edge 11->01 -> step, dir=1.
